round_robin_encoder_arbiter: RTL and testbench

ROUND_ROBIN_ENCODER_ARBITER -- requirements
Module: round_robin_encoder_arbiter

---
 rtl/round_robin_encoder_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_round_robin_encoder_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/round_robin_encoder_arbiter.sv
// Round-robin arbiter for 10 requesters with registered one-hot and binary grant.
// A grant is held while its owner keeps requesting; release costs one idle cycle,
// and the released owner is ranked last in the next rotation.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a grant held for TIMEOUT_CYCLES cycles is revoked through a
//                one-cycle REVOKE state that pulses timeout
//   undefined -> grants are held indefinitely; timeout is tied low
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous active-high reset
//   req          in  10   request lines, requester 0..9
//   grant        out 10   one-hot grant (registered)
//   grant_idx    out  4   binary index of granted requester, 0 when idle (registered)
//   grant_valid  out  1   high while a grant is held (registered)
//   timeout      out  1   one-cycle pulse on timer revocation (registered)
module round_robin_encoder_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] req,
    output logic [9:0] grant,
    output logic [3:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    localparam int unsigned NREQ = 10;
    localparam int unsigned IDXW = 4;
    localparam int unsigned SUMW = IDXW + 1;

    // Elaboration-time guard on the parameter range
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("round_robin_encoder_arbiter: TIMEOUT_CYCLES must be 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNTW = 8;
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REVOKE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [IDXW-1:0]   last_q;
    logic [IDXW-1:0]   last_d;
    logic [NREQ-1:0]   grant_d;
    logic [IDXW-1:0]   grant_idx_d;
    logic              grant_valid_d;

    logic [IDXW-1:0]   win_idx;
    logic [SUMW-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
    logic [CNTW-1:0]   hold_cnt_q;
    logic [CNTW-1:0]   hold_cnt_d;
    logic              timeout_d;
`endif

    // Rotating priority search: candidates last+1 .. last+10 (mod 10).
    // Scanning from the far end backwards lets the nearest set bit overwrite.
    always_comb begin : search
        win_idx = '0;
        cand    = '0;
        for (int i = int'(NREQ); i >= 1; i--) begin
            cand = SUMW'(last_q) + SUMW'(i);
            if (cand >= SUMW'(NREQ)) begin
                cand = cand - SUMW'(NREQ);
            end
            if (req[cand[IDXW-1:0]]) begin
                win_idx = cand[IDXW-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin : fsm_next
        state_d       = state_q;
        last_d        = last_q;
        grant_d       = grant;
        grant_idx_d   = grant_idx;
        grant_valid_d = grant_valid;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
                if (|req) begin
                    state_d          = GRANT;
                    grant_d[win_idx] = 1'b1;
                    grant_idx_d      = win_idx;
                    grant_valid_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d       = '0;
`endif
                end
            end

            GRANT: begin
                // Release has priority over timer expiry on the same edge
                if (!req[grant_idx]) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    last_d        = grant_idx;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == HOLD_LAST) begin
                    // Grant has now been visible for TIMEOUT_CYCLES cycles
                    state_d       = REVOKE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    grant_valid_d = 1'b0;
                    timeout_d     = 1'b1;
                    last_d        = grant_idx;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNTW'(1);
                end
`endif
            end

`ifdef ARB_TIMEOUT_EN
            REVOKE: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
            end
`endif

            default: begin
                state_d       = IDLE;
                grant_d       = '0;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin : fsm_reg
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDXW'(NREQ - 1);
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant       <= grant_d;
            grant_idx   <= grant_idx_d;
            grant_valid <= grant_valid_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q  <= hold_cnt_d;
            timeout     <= timeout_d;
`endif
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_round_robin_encoder_arbiter.sv
// Self-checking bench for round_robin_encoder_arbiter: vector table plus
// hand-written multi-cycle sequences, expected results routed through a queue.
module tb_round_robin_encoder_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] req = '0;
    logic [9:0] grant;
    logic [3:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    round_robin_encoder_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] grant;
        logic [3:0] idx;
        logic       valid;
        logic       to;
    } obs_t;

    typedef struct packed {
        logic [9:0] req;
        logic       valid;
        logic [3:0] idx;
        logic       to;
    } vec_t;

    obs_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic obs_t mk(input logic v, input logic [3:0] i, input logic t);
        obs_t o;
        o.grant = v ? (10'(1) << i) : 10'd0;
        o.idx   = v ? i : 4'd0;
        o.valid = v;
        o.to    = t;
        return o;
    endfunction

    task automatic check_out(input string nm);
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = '{grant, grant_idx, grant_valid, timeout};
        total++;
        if (a == e) begin
            passed++;
        end else begin
            $display("FAIL %s: got grant=%b idx=%0d valid=%b timeout=%b, want grant=%b idx=%0d valid=%b timeout=%b",
                     nm, a.grant, a.idx, a.valid, a.to, e.grant, e.idx, e.valid, e.to);
        end
    endtask

    // Drive req, queue the expected post-edge outputs, compare after the edge
    task automatic step(input logic [9:0] r, input obs_t e, input string nm);
        req = r;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(mk(1'b0, 4'd0, 1'b0));
        check_out("reset_state");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    vec_t tbl [0:17];

    initial begin : main
        logic [3:0] own;

        // req, valid, idx, timeout  (expected outputs after the edge)
        tbl[0]  = '{10'h004, 1'b1, 4'd2, 1'b0};  // first search from 0 -> 2
        tbl[1]  = '{10'h004, 1'b1, 4'd2, 1'b0};  // hold
        tbl[2]  = '{10'h000, 1'b0, 4'd0, 1'b0};  // release, last=2
        tbl[3]  = '{10'h000, 1'b0, 4'd0, 1'b0};  // stay idle
        tbl[4]  = '{10'h00B, 1'b1, 4'd3, 1'b0};  // search from 3 -> 3
        tbl[5]  = '{10'h0FF, 1'b1, 4'd3, 1'b0};  // other reqs ignored
        tbl[6]  = '{10'h0F7, 1'b0, 4'd0, 1'b0};  // release, last=3
        tbl[7]  = '{10'h0F7, 1'b1, 4'd4, 1'b0};  // search from 4 -> 4
        tbl[8]  = '{10'h0E0, 1'b0, 4'd0, 1'b0};  // release, last=4
        tbl[9]  = '{10'h208, 1'b1, 4'd9, 1'b0};  // from 5 -> 9
        tbl[10] = '{10'h008, 1'b0, 4'd0, 1'b0};  // release, last=9
        tbl[11] = '{10'h208, 1'b1, 4'd3, 1'b0};  // wrap, from 0 -> 3
        tbl[12] = '{10'h000, 1'b0, 4'd0, 1'b0};  // release, last=3
        tbl[13] = '{10'h008, 1'b1, 4'd3, 1'b0};  // sole requester is last -> 3
        tbl[14] = '{10'h018, 1'b1, 4'd3, 1'b0};  // hold
        tbl[15] = '{10'h010, 1'b0, 4'd0, 1'b0};  // release, last=3
        tbl[16] = '{10'h018, 1'b1, 4'd4, 1'b0};  // re-raised owner ranked last
        tbl[17] = '{10'h000, 1'b0, 4'd0, 1'b0};  // release

        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].req, mk(tbl[i].valid, tbl[i].idx, tbl[i].to), $sformatf("vec%0d", i));
        end

        // Two requesters alternate, each holding 3 cycles
        do_reset();
        for (int k = 0; k < 4; k++) begin
            own = (k % 2 == 0) ? 4'd0 : 4'd9;
            for (int c = 0; c < 3; c++) begin
                step(10'h201, mk(1'b1, own, 1'b0), $sformatf("alt_grant%0d_c%0d", k, c));
            end
            step(10'h201 & ~(10'(1) << own), mk(1'b0, 4'd0, 1'b0), $sformatf("alt_idle%0d", k));
        end

        // All requesting, one-cycle holds: ascending order with wrap
        do_reset();
        for (int k = 0; k < 11; k++) begin
            own = 4'(k % 10);
            step(10'h3FF, mk(1'b1, own, 1'b0), $sformatf("fair_grant%0d", k));
            step(10'h3FF & ~(10'(1) << own), mk(1'b0, 4'd0, 1'b0), $sformatf("fair_idle%0d", k));
        end

        // Async reset mid-grant drops outputs without a clock edge
        do_reset();
        step(10'h020, mk(1'b1, 4'd5, 1'b0), "pre_rst_grant5");
        step(10'h020, mk(1'b1, 4'd5, 1'b0), "pre_rst_hold5");
        #2;
        rst = 1'b1;
        #1;
        exp_q.push_back(mk(1'b0, 4'd0, 1'b0));
        check_out("async_rst_drop");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(10'h3FF, mk(1'b1, 4'd0, 1'b0), "post_rst_grant0");

`ifdef ARB_TIMEOUT_EN
        // Timer revocation with sole requester 3
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step(10'h008, mk(1'b1, 4'd3, 1'b0), $sformatf("to_hold_c%0d", c));
        end
        step(10'h008, mk(1'b0, 4'd0, 1'b1), "to_revoke");
        step(10'h008, mk(1'b0, 4'd0, 1'b0), "to_idle");
        step(10'h008, mk(1'b1, 4'd3, 1'b0), "to_regrant");
        // Release on the expiry edge wins, no pulse
        for (int c = 0; c < 3; c++) begin
            step(10'h008, mk(1'b1, 4'd3, 1'b0), $sformatf("to_race_c%0d", c));
        end
        step(10'h000, mk(1'b0, 4'd0, 1'b0), "to_race_release");
        step(10'h000, mk(1'b0, 4'd0, 1'b0), "to_race_idle");
`else
        // No timer: grant held indefinitely
        do_reset();
        for (int c = 0; c < 1000; c++) begin
            step(10'h080, mk(1'b1, 4'd7, 1'b0), "hold7_forever");
        end
        step(10'h000, mk(1'b0, 4'd0, 1'b0), "hold7_release");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
